// File: rtl/instr_fetch_seq_pkg.sv
// rtl/instr_fetch_seq_pkg.sv - shared state codes, default widths and fetch-timeout limit
package instr_fetch_seq_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 20;

  // REQ cycles without mem_ack before the sequencer gives up
  localparam logic [3:0] TIMEOUT_LIMIT = 4'd15;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_REQ  = 3'd1;
  localparam state_t ST_LOAD = 3'd2;
  localparam state_t ST_HOLD = 3'd3;
  localparam state_t ST_ERR  = 3'd4;

endpackage

// File: rtl/instr_fetch_seq_fetch_pc.sv
// rtl/instr_fetch_seq_fetch_pc.sv - program counter with increment, natural wrap and jump load
module fetch_pc
  import instr_fetch_seq_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Jump wins over increment; the two never coincide in the sequencer anyway
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - instruction fetch sequencer FSM with registered outputs
// Optional fetch timeout and sticky err flag enabled by FETCH_TIMEOUT_EN.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stall,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir_data,
  output logic              ir_enable,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              err
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_data_q, ir_data_d;
  logic              mem_req_q, mem_req_d;
  logic              ir_enable_q, ir_enable_d;
  logic              busy_q, busy_d;
  logic              pc_inc, pc_load;
`ifdef FETCH_TIMEOUT_EN
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    ir_data_d = ir_data_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: if (run) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_ack) begin
          state_d   = ST_LOAD;
          ir_data_d = mem_data;
`ifdef FETCH_TIMEOUT_EN
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TIMEOUT_LIMIT) state_d = ST_ERR;
`endif
        end
      end
      ST_LOAD: begin
        if (!run)       state_d = ST_IDLE;
        else if (stall) state_d = ST_HOLD;
        else            state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (!run)        state_d = ST_IDLE;
        else if (!stall) state_d = ST_REQ;
      end
`ifdef FETCH_TIMEOUT_EN
      ST_ERR:  state_d = ST_ERR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    mem_req_d   = (state_d == ST_REQ);
    ir_enable_d = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
`ifdef FETCH_TIMEOUT_EN
    err_d       = err_q | (state_d == ST_ERR);
`endif
  end

  assign pc_inc  = (state_q == ST_LOAD);
  assign pc_load = jmp && ((state_q == ST_IDLE) || (state_q == ST_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ir_data_q   <= '0;
      mem_req_q   <= 1'b0;
      ir_enable_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ir_data_q   <= ir_data_d;
      mem_req_q   <= mem_req_d;
      ir_enable_q <= ir_enable_d;
      busy_q      <= busy_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET)
  ) u_fetch_pc (
    .clk       (clk),
    .rst       (rst),
    .inc       (pc_inc),
    .load      (pc_load),
    .load_addr (jmp_addr),
    .pc        (pc)
  );

  assign mem_req   = mem_req_q;
  assign mem_addr  = pc;
  assign ir_data   = ir_data_q;
  assign ir_enable = ir_enable_q;
  assign busy      = busy_q;
`ifdef FETCH_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - directed and randomized checks of instr_fetch_seq against a PC model
module tb_instr_fetch_seq;

  localparam int AW = 10;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          stall = 1'b0;
  logic          jmp = 1'b0;
  logic [AW-1:0] jmp_addr = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] ir_data;
  logic          ir_enable;
  logic [AW-1:0] pc;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_seq dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .stall     (stall),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .ir_data   (ir_data),
    .ir_enable (ir_enable),
    .pc        (pc),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered with a request visible; returns one cycle into the load phase
  task automatic fetch(input string tag, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input int delay);
    for (int d = 0; d < delay; d++) begin
      chk({tag, ".wait_req"}, 32'(mem_req), 1);
      chk({tag, ".wait_addr"}, 32'(mem_addr), 32'(addr));
      chk({tag, ".wait_ire"}, 32'(ir_enable), 0);
      tick();
    end
    chk({tag, ".req"}, 32'(mem_req), 1);
    chk({tag, ".addr"}, 32'(mem_addr), 32'(addr));
    mem_ack  = 1'b1;
    mem_data = data;
    tick();
    mem_ack  = 1'b0;
    mem_data = DW'($urandom);
    chk({tag, ".ire"}, 32'(ir_enable), 1);
    chk({tag, ".ir_data"}, 32'(ir_data), 32'(data));
    chk({tag, ".req_drop"}, 32'(mem_req), 0);
    chk({tag, ".busy"}, 32'(busy), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] mpc;
    logic [DW-1:0] dat;
    int            nf;
    logic          st;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.mem_req", 32'(mem_req), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.ir_enable", 32'(ir_enable), 0);
    chk("rst.ir_data", 32'(ir_data), 0);
    chk("rst.pc", 32'(pc), 0);

    // Basic fetch from address 0
    run = 1'b1;
    chk("f0.pre_req", 32'(mem_req), 0);
    tick();
    chk("f0.busy", 32'(busy), 1);
    fetch("f0", 10'h000, 20'hABCDE, 0);
    run = 1'b0;
    tick();
    chk("f0.pc", 32'(pc), 1);
    chk("f0.ire_off", 32'(ir_enable), 0);
    chk("f0.idle_busy", 32'(busy), 0);
    chk("f0.ir_hold", 32'(ir_data), 32'h000ABCDE);
    tick();
    chk("f0.ir_hold2", 32'(ir_data), 32'h000ABCDE);

    // Jump in IDLE to the top address, then wrap
    jmp = 1'b1;
    jmp_addr = 10'h3FF;
    tick();
    jmp = 1'b0;
    chk("wrap.pc_jmp", 32'(pc), 32'h3FF);
    chk("wrap.idle", 32'(busy), 0);
    run = 1'b1;
    tick();
    fetch("wrap", 10'h3FF, 20'h12345, 1);
    run = 1'b0;
    tick();
    chk("wrap.pc", 32'(pc), 0);

    // Stall into HOLD, jump and release in the same cycle
    run = 1'b1;
    tick();
    fetch("hold", 10'h000, 20'h0F0F0, 0);
    stall = 1'b1;
    tick();
    chk("hold.mem_req", 32'(mem_req), 0);
    chk("hold.busy", 32'(busy), 1);
    chk("hold.pc", 32'(pc), 1);
    chk("hold.ire", 32'(ir_enable), 0);
    tick();
    chk("hold.still", 32'(mem_req), 0);
    jmp = 1'b1;
    jmp_addr = 10'h040;
    stall = 1'b0;
    tick();
    jmp = 1'b0;
    chk("hold.jmp_addr", 32'(mem_addr), 32'h040);
    fetch("hj", 10'h040, 20'h55555, 0);
    tick();
    chk("b2b.req", 32'(mem_req), 1);
    chk("b2b.addr", 32'(mem_addr), 32'h041);

    // Jump is ignored while a request is outstanding
    jmp = 1'b1;
    jmp_addr = 10'h155;
    tick();
    jmp = 1'b0;
    chk("jmp_ign.addr", 32'(mem_addr), 32'h041);

    // run dropped mid-request, ack four cycles later
    run = 1'b0;
    fetch("late", 10'h041, 20'hFEDCB, 3);
    tick();
    chk("late.ire_off", 32'(ir_enable), 0);
    chk("late.idle", 32'(busy), 0);
    chk("late.pc", 32'(pc), 32'h042);
    chk("late.no_req", 32'(mem_req), 0);

    // Reset during REQ, late ack ignored
    run = 1'b1;
    tick();
    chk("rreq.req", 32'(mem_req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run = 1'b0;
    chk("rreq.mem_req", 32'(mem_req), 0);
    chk("rreq.pc", 32'(pc), 0);
    chk("rreq.ir_data", 32'(ir_data), 0);
    mem_ack = 1'b1;
    mem_data = 20'h77777;
    tick();
    mem_ack = 1'b0;
    chk("rreq.late_ire", 32'(ir_enable), 0);
    chk("rreq.late_ir", 32'(ir_data), 0);
    chk("rreq.late_busy", 32'(busy), 0);

    // Unanswered request
    run = 1'b1;
    tick();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      chk("to.req", 32'(mem_req), 1);
      chk("to.err0", 32'(err), 0);
      tick();
    end
    chk("to.err", 32'(err), 1);
    chk("to.req_drop", 32'(mem_req), 0);
    chk("to.busy", 32'(busy), 1);
    run = 1'b0;
    tick();
    tick();
    chk("to.sticky", 32'(err), 1);
`else
    for (int i = 0; i < 20; i++) begin
      chk("nto.req", 32'(mem_req), 1);
      chk("nto.err", 32'(err), 0);
      tick();
    end
    run = 1'b0;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to.rst_err", 32'(err), 0);
    chk("to.rst_busy", 32'(busy), 0);

    // Randomized bursts against a PC model
    mpc = '0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        jmp = 1'b1;
        jmp_addr = AW'($urandom);
        mpc = jmp_addr;
      end
      run = 1'b1;
      tick();
      jmp = 1'b0;
      nf = int'($urandom_range(1, 3));
      for (int f = 0; f < nf; f++) begin
        dat = DW'($urandom);
        fetch("rnd", mpc, dat, int'($urandom_range(0, 4)));
        st = 1'b0;
        if (f == nf - 1) run = 1'b0;
        else begin
          st = 1'($urandom_range(0, 1));
          stall = st;
        end
        tick();
        mpc = mpc + AW'(1);
        chk("rnd.pc", 32'(pc), 32'(mpc));
        chk("rnd.ire_off", 32'(ir_enable), 0);
        chk("rnd.ir_hold", 32'(ir_data), 32'(dat));
        if (st) begin
          chk("rnd.hold_req", 32'(mem_req), 0);
          if ($urandom_range(0, 1) == 1) begin
            jmp = 1'b1;
            jmp_addr = AW'($urandom);
            mpc = jmp_addr;
          end
          stall = 1'b0;
          tick();
          jmp = 1'b0;
        end
      end
      chk("rnd.idle", 32'(busy), 0);
      chk("rnd.idle_req", 32'(mem_req), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
